// File: rtl/packet_stream_arbiter.sv
// Four-source packet stream arbiter.
// Round-robin selection at packet boundaries merges the sources into one
// registered stream. An owner that stalls for TIMEOUT cycles inside a packet
// is cut off with a synthetic end-of-packet beat.
module packet_stream_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   src_valid,
    input  logic [3:0]   src_sop,
    input  logic [3:0]   src_eop,
    input  logic [127:0] src_data,
    output logic [3:0]   src_ready,
    output logic [3:0]   grant,
    output logic         out_valid,
    output logic         out_sop,
    output logic         out_eop,
    output logic [31:0]  out_data,
    output logic         busy,
    output logic         timeout_err,
    output logic [3:0]   timeout_count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]  state;
    logic [1:0]  last_grant;
    logic [7:0]  idle_cnt;
    logic [3:0]  req;
    logic        any_req;
    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic [1:0]  owner_idx;
    logic        xfer;
    logic        owner_sop;
    logic        owner_eop;
    logic [31:0] owner_data;
    logic        timeout_hit;

    // A request is a valid start-of-packet beat; anything else waits.
    assign req     = src_valid & src_sop;
    assign any_req = (req != 4'b0);

    // Grant is one-hot while a packet is owned, so a simple OR encode suffices.
    assign owner_idx  = {grant[3] | grant[2], grant[3] | grant[1]};
    assign xfer       = (state == XFER) && ((src_valid & grant) != 4'b0);
    assign owner_sop  = src_sop[owner_idx];
    assign owner_eop  = src_eop[owner_idx];
    assign owner_data = src_data[{owner_idx, 5'd0} +: 32];

    // A beat moving on the same cycle always beats the timeout.
    assign timeout_hit = (state == XFER) && !xfer && (idle_cnt == 8'(TIMEOUT));

    assign src_ready = grant;
    assign busy      = (state == XFER);

    // Round-robin search starting just after the previous owner; nearest wins.
    always_comb begin
        win_idx = last_grant;
        cand    = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_grant + 2'(k);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

    // Ownership FSM, idle watchdog and the registered merged output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= 4'b0;
            last_grant    <= 2'd3;
            idle_cnt      <= 8'd0;
            out_valid     <= 1'b0;
            out_sop       <= 1'b0;
            out_eop       <= 1'b0;
            out_data      <= 32'd0;
            timeout_err   <= 1'b0;
            timeout_count <= 4'd0;
        end else begin
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= 4'b0001 << win_idx;
                        idle_cnt <= 8'd0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (xfer) begin
                        out_valid <= 1'b1;
                        out_sop   <= owner_sop;
                        out_eop   <= owner_eop;
                        out_data  <= owner_data;
                        idle_cnt  <= 8'd0;
                        if (owner_eop) begin
                            grant      <= 4'b0;
                            last_grant <= owner_idx;
                            state      <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        out_valid   <= 1'b1;
                        out_eop     <= 1'b1;
                        out_data    <= 32'd0;
                        timeout_err <= 1'b1;
                        if (timeout_count != 4'hF) begin
                            timeout_count <= timeout_count + 4'd1;
                        end
                        grant      <= 4'b0;
                        last_grant <= owner_idx;
                        state      <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                default: begin
                    grant <= 4'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_stream_arbiter.sv
// Directed bench for packet_stream_arbiter: behavioural sources feed packets,
// merged beats and grant changes are recorded and compared to hand-built lists.
module tb_packet_stream_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   src_valid;
    logic [3:0]   src_sop;
    logic [3:0]   src_eop;
    logic [127:0] src_data;
    logic [3:0]   src_ready;
    logic [3:0]   grant;
    logic         out_valid;
    logic         out_sop;
    logic         out_eop;
    logic [31:0]  out_data;
    logic         busy;
    logic         timeout_err;
    logic [3:0]   timeout_count;

    packet_stream_arbiter #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_valid     (src_valid),
        .src_sop       (src_sop),
        .src_eop       (src_eop),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .grant         (grant),
        .out_valid     (out_valid),
        .out_sop       (out_sop),
        .out_eop       (out_eop),
        .out_data      (out_data),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .timeout_count (timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // source model state
    int pkts[4];
    int len[4];
    int beat[4];
    int pktno[4];
    int gap_cfg[4];
    int gap_rem[4];
    bit abandon[4];

    // observation records
    logic [33:0] oq[$];
    logic [3:0]  gq[$];
    logic [3:0]  gprev;
    int cyc;
    int terr_n;
    int bad_ready;
    int t_sop;
    int t_eop;
    logic [31:0] eop_data;

    function automatic logic [31:0] bd(input int s, input int p, input int b);
        bd = {4'hA, 4'(s), 8'(p), 16'(b)};
    endfunction

    function automatic logic [33:0] eb(input int s, input int p, input int b, input int l);
        eb = {(b == 0), (b == l - 1), bd(s, p, b)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            src_valid[i] = (pkts[i] > 0) && (gap_rem[i] == 0);
            src_sop[i]   = (beat[i] == 0);
            src_eop[i]   = (beat[i] == len[i] - 1);
            src_data[32*i +: 32] = bd(i, pktno[i], beat[i]);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            pkts[i] = 0; len[i] = 1; beat[i] = 0; pktno[i] = 0;
            gap_cfg[i] = 0; gap_rem[i] = 0; abandon[i] = 1'b0;
        end
        drive();
    endtask

    task automatic clear_obs();
        oq.delete();
        gq.delete();
        gprev = grant;
        terr_n = 0;
        bad_ready = 0;
        t_sop = -1;
        t_eop = -1;
        eop_data = 32'hFFFF_FFFF;
    endtask

    // one clock: note transfers before the edge, observe after it, advance sources
    task automatic cycle();
        logic [3:0] x;
        x = src_valid & src_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) oq.push_back({out_sop, out_eop, out_data});
        if (out_valid && out_sop) t_sop = cyc;
        if (out_valid && out_eop) begin
            t_eop = cyc;
            eop_data = out_data;
        end
        if (timeout_err) terr_n++;
        if (grant !== gprev) begin
            gq.push_back(grant);
            gprev = grant;
        end
        if (((src_ready & ~grant) != 4'b0) || !$onehot0(grant)) bad_ready++;
        for (int i = 0; i < 4; i++) begin
            if (x[i]) begin
                if (beat[i] == 0 && abandon[i]) begin
                    pkts[i] = 0;
                    beat[i] = 0;
                end else if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    pkts[i]--;
                    pktno[i]++;
                end else begin
                    if (beat[i] == 0 && gap_cfg[i] > 0) gap_rem[i] = gap_cfg[i];
                    beat[i]++;
                end
            end else if (gap_rem[i] > 0) begin
                gap_rem[i]--;
            end
        end
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_grant"}, 64'(grant), 64'h0);
        chk({pfx, "_ready"}, 64'(src_ready), 64'h0);
        chk({pfx, "_ovalid"}, 64'(out_valid), 64'h0);
        chk({pfx, "_osop"}, 64'(out_sop), 64'h0);
        chk({pfx, "_oeop"}, 64'(out_eop), 64'h0);
        chk({pfx, "_odata"}, 64'(out_data), 64'h0);
        chk({pfx, "_busy"}, 64'(busy), 64'h0);
        chk({pfx, "_terr"}, 64'(timeout_err), 64'h0);
        chk({pfx, "_tcount"}, 64'(timeout_count), 64'h0);
    endtask

    task automatic do_reset(input string pfx);
        rst = 1'b1;
        clear_src();
        @(posedge clk);
        #1;
        chk_reset_outputs(pfx);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        clear_obs();
    endtask

    initial begin
        logic [3:0] g_exp[16];
        rst = 1'b1;
        cyc = 0;
        clear_src();
        clear_obs();

        // reset state
        do_reset("rst0");

        // single 5-beat packet from source 2
        pkts[2] = 1; len[2] = 5;
        drive();
        cycle();
        chk("t32_grant", 64'(grant), 64'h4);
        chk("t32_busy", 64'(busy), 64'h1);
        run(10);
        chk("t32_nbeats", 64'(oq.size()), 64'd5);
        for (int b = 0; b < 5; b++)
            chk($sformatf("t32_beat%0d", b), 64'(oq[b]), 64'(eb(2, 0, b, 5)));
        chk("t32_ngrant", 64'(gq.size()), 64'd2);
        chk("t32_g0", 64'(gq[0]), 64'h4);
        chk("t32_g1", 64'(gq[1]), 64'h0);
        chk("t32_hold", 64'(out_data), 64'(bd(2, 0, 4)));

        // simultaneous 0/1 requests after reset
        do_reset("rst1");
        pkts[0] = 1; len[0] = 2;
        pkts[1] = 1; len[1] = 2;
        drive();
        run(12);
        chk("t33_ngrant", 64'(gq.size()), 64'd4);
        chk("t33_g0", 64'(gq[0]), 64'h1);
        chk("t33_g1", 64'(gq[1]), 64'h0);
        chk("t33_g2", 64'(gq[2]), 64'h2);
        chk("t33_g3", 64'(gq[3]), 64'h0);
        chk("t33_nbeats", 64'(oq.size()), 64'd4);
        chk("t33_b0", 64'(oq[0]), 64'(eb(0, 0, 0, 2)));
        chk("t33_b1", 64'(oq[1]), 64'(eb(0, 0, 1, 2)));
        chk("t33_b2", 64'(oq[2]), 64'(eb(1, 0, 0, 2)));
        chk("t33_b3", 64'(oq[3]), 64'(eb(1, 0, 1, 2)));

        // all four requesting continuously, two 2-beat packets each
        do_reset("rst2");
        for (int i = 0; i < 4; i++) begin
            pkts[i] = 2; len[i] = 2;
        end
        drive();
        run(40);
        g_exp = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0,
                  4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
        chk("t34_ngrant", 64'(gq.size()), 64'd16);
        for (int k = 0; k < 16; k++)
            chk($sformatf("t34_g%0d", k), 64'(gq[k]), 64'(g_exp[k]));
        chk("t34_nbeats", 64'(oq.size()), 64'd16);
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++)
                for (int b = 0; b < 2; b++)
                    chk($sformatf("t34_r%0d_s%0d_b%0d", r, s, b),
                        64'(oq[r*8 + s*2 + b]), 64'(eb(s, r, b, 2)));
        chk("t34_ready_owner_only", 64'(bad_ready), 64'd0);

        // source 3 stalls after sop -> forced termination
        clear_src();
        clear_obs();
        pkts[3] = 1; len[3] = 4; abandon[3] = 1'b1;
        drive();
        run(25);
        chk("t35_nbeats", 64'(oq.size()), 64'd2);
        chk("t35_sop_beat", 64'(oq[0]), 64'(eb(3, 0, 0, 4)));
        chk("t35_forced_beat", 64'(oq[1]), {30'd0, 2'b01, 32'd0});
        chk("t35_latency", 64'(t_eop - t_sop), 64'd17);
        chk("t35_eop_data", 64'(eop_data), 64'h0);
        chk("t35_terr_pulses", 64'(terr_n), 64'd1);
        chk("t35_tcount", 64'(timeout_count), 64'd1);
        chk("t35_grant", 64'(grant), 64'h0);
        chk("t35_busy", 64'(busy), 64'h0);

        // eop arrives on the very cycle the idle counter sits at TIMEOUT
        clear_src();
        clear_obs();
        pkts[1] = 1; len[1] = 2; gap_cfg[1] = 16;
        drive();
        run(30);
        chk("t28_nbeats", 64'(oq.size()), 64'd2);
        chk("t28_b0", 64'(oq[0]), 64'(eb(1, 0, 0, 2)));
        chk("t28_b1", 64'(oq[1]), 64'(eb(1, 0, 1, 2)));
        chk("t28_latency", 64'(t_eop - t_sop), 64'd17);
        chk("t28_terr_pulses", 64'(terr_n), 64'd0);
        chk("t28_tcount", 64'(timeout_count), 64'd1);

        // timeouts 2..17: counter saturates at 15
        for (int k = 2; k <= 17; k++) begin
            clear_src();
            pkts[k % 4] = 1; len[k % 4] = 3; abandon[k % 4] = 1'b1;
            drive();
            run(22);
            chk($sformatf("t36_tcount_%0d", k), 64'(timeout_count),
                64'((k > 15) ? 15 : k));
        end

        // reset in the middle of a source 1 packet, after a source 0 packet
        clear_src();
        clear_obs();
        pkts[0] = 1; len[0] = 2;
        drive();
        run(6);
        pkts[1] = 1; len[1] = 6;
        drive();
        run(4);
        chk("t37_pre_grant", 64'(grant), 64'h2);
        chk("t37_pre_busy", 64'(busy), 64'h1);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("t37_async");
        clear_src();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_obs();
        pkts[0] = 1; len[0] = 2;
        pkts[1] = 1; len[1] = 2;
        drive();
        cycle();
        chk("t37_first_grant", 64'(grant), 64'h1);
        run(10);
        chk("t37_terr_pulses", 64'(terr_n), 64'd0);
        chk("t37_nbeats", 64'(oq.size()), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_stream_arbiter.md
PACKET_STREAM_ARBITER -- requirements
Module: packet_stream_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, idle-cycle limit inside a granted packet; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 src_valid  input  4  per-source beat valid; bit i = source i.
REQ-005 src_sop  input  4  per-source start-of-packet marker.
REQ-006 src_eop  input  4  per-source end-of-packet marker.
REQ-007 src_data  input  128  packed payload; source i at [32i+31:32i].
REQ-008 src_ready  output  4  per-source accept; one-hot or zero.
REQ-009 grant  output  4  current owner, one-hot or zero.
REQ-010 out_valid  output  1  merged stream beat valid, feeds packet_parser data_valid.
REQ-011 out_sop  output  1  merged start_of_packet.
REQ-012 out_eop  output  1  merged end_of_packet.
REQ-013 out_data  output  32  merged packet_data_in.
REQ-014 busy  output  1  high while state is XFER.
REQ-015 timeout_err  output  1  one-cycle pulse on forced packet termination.
REQ-016 timeout_count  output  4  forced terminations, saturating at 15.

Function
REQ-017 FSM states IDLE, XFER only; transitions evaluated each clk edge.
REQ-018 Request i = src_valid[i] & src_sop[i]; beats from ungranted sources are never transferred.
REQ-019 IDLE with any request: select winner round-robin, searching last_grant+1, +2, +3, +4 (mod 4); grant[i]=1, src_ready[i]=1, state XFER from next cycle.
REQ-020 IDLE with no request: grant=0, src_ready=0, stay IDLE.
REQ-021 Transfer occurs on cycle where src_valid[i] & src_ready[i]; source holds sop beat stable until transferred.
REQ-022 Each transferred beat appears on out_valid/out_sop/out_eop/out_data exactly one cycle later (registered); non-transfer cycles drive out_valid=out_sop=out_eop=0, out_data holds last value.
REQ-023 Transferred beat with src_eop[i]=1: last_grant<=i, grant and src_ready drop next cycle, state IDLE; minimum one idle cycle between packets.
REQ-024 Single-beat packet (sop and eop same beat): one transfer, then IDLE per REQ-023.
REQ-025 Repeated sop from owner mid-packet passes through unmodified; no re-arbitration until eop.
REQ-026 Idle counter: in XFER, increments each cycle with src_valid[i]=0, clears on any transferred beat, width 8 bits.
REQ-027 Idle counter reaching TIMEOUT: next cycle out_valid=1, out_eop=1, out_sop=0, out_data=0; timeout_err=1 for that cycle; timeout_count+1 unless 15; grant drops; last_grant<=i; state IDLE.
REQ-028 Timeout and owner eop beat on same cycle: eop wins, no timeout_err, count unchanged.
REQ-029 Requests arriving while XFER are held pending by source; evaluated only in IDLE.

Reset
REQ-030 While rst=1: state IDLE, grant=0, src_ready=0, out_valid=out_sop=out_eop=0, out_data=0, busy=0, timeout_err=0, timeout_count=0, idle counter=0, last_grant=3.
REQ-031 rst asserted mid-packet aborts immediately, no eop emitted; first post-reset arbitration favours source 0.

Verification
REQ-032 Reset then src 2 sends sop/3 data/eop, valid continuous -> grant=4'b0100 one cycle after request, 5 out_valid beats ending out_eop=1, data order preserved, grant=0 after.
REQ-033 Sources 0 and 1 request simultaneously after reset -> source 0 granted first, source 1 granted second cycle after source 0 eop transferred.
REQ-034 All four request continuously, 2-beat packets -> grant order 0,1,2,3,0; no src_ready to non-owner ever.
REQ-035 Source 3 sends sop then drops src_valid, TIMEOUT=16 -> 16 idle cycles then out_eop=1 with out_data=0, timeout_err one pulse, timeout_count=1, IDLE.
REQ-036 17 forced timeouts -> timeout_count sticks at 15.
REQ-037 rst pulsed during source 1 packet -> outputs zero asynchronously; next simultaneous 0/1 request grants source 0.
